axi4_lite_slave_regbank: RTL and testbench

- Parametrised AXI4-Lite slave that terminates the control bus and holds a bank of NUM_REGS read/write configuration registers.
- Generalises the fixed 8-bit address / 32-bit data control port to configurable address width, data width and register count.
- Adds independent AW/W acceptance, SLVERR decode for out-of-range addresses, and per-register write-event pulses.
- Sits between the AXI4-Lite master (testbench driver or CPU) and the I2S transmitter datapath, which consumes reg_q.

---
 rtl/axi4_lite_slv_pkg.sv | 21 ++
 rtl/axi4_lite_slv_addr_dec.sv | 24 ++
 rtl/axi4_lite_slave_regbank.sv | 184 ++++++++++++++++++
 tb/tb_axi4_lite_slave_regbank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_slv_pkg.sv
// Shared definitions for the AXI4-Lite register bank slave.
//   RESP_OKAY / RESP_SLVERR : AXI response codes returned on B and R.
//   wr_state_e              : write channel FSM states.
//   rd_state_e              : read channel FSM states.
package axi4_lite_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_COMMIT,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_slv_addr_dec.sv
// Byte address to register index decoder.
//   addr     in  ADDR_WIDTH          byte address from AW or AR
//   idx      out ADDR_WIDTH-ADDR_LSB word index (low byte-offset bits dropped)
//   in_range out 1                   idx < NUM_REGS
module axi4_lite_slv_addr_dec
  import axi4_lite_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int ADDR_LSB   = 2,
  parameter int NUM_REGS   = 16
) (
  input  logic [ADDR_WIDTH-1:0]          addr,
  output logic [ADDR_WIDTH-ADDR_LSB-1:0] idx,
  output logic                           in_range
);

  // Byte offset within a word carries no meaning for a word-wide register.
  logic unused_lsb;
  assign unused_lsb = ^addr[ADDR_LSB-1:0];

  assign idx      = addr[ADDR_WIDTH-1:ADDR_LSB];
  assign in_range = 32'(idx) < 32'(NUM_REGS);

endmodule

// File: rtl/axi4_lite_slave_regbank.sv
// AXI4-Lite slave holding NUM_REGS read/write configuration registers.
// Optional feature macro: AXI4L_SLV_WSTRB_EN adds s_axi_ctrl_wstrb and
// byte-lane writes; without it every write replaces the whole word.
// Ports:
//   s_axi_ctrl_aclk / s_axi_ctrl_aresetn : clock, synchronous active-low reset
//   s_axi_ctrl_aw*, w*, b*               : write address / data / response
//   s_axi_ctrl_ar*, r*                   : read address / data
//   reg_q        : flattened registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse : one-cycle strobe per register, aligned with the cycle the
//                  new value first appears on reg_q (also the first bvalid cycle)
// Out-of-range indices answer SLVERR, write nothing and read as zero.
// DATA_WIDTH must be 32 or 64; NUM_REGS*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.
module axi4_lite_slave_regbank
  import axi4_lite_slv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           s_axi_ctrl_aclk,
  input  logic                           s_axi_ctrl_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_ctrl_awaddr,
  input  logic                           s_axi_ctrl_awvalid,
  output logic                           s_axi_ctrl_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_ctrl_wdata,
`ifdef AXI4L_SLV_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        s_axi_ctrl_wstrb,
`endif
  input  logic                           s_axi_ctrl_wvalid,
  output logic                           s_axi_ctrl_wready,
  output logic [1:0]                     s_axi_ctrl_bresp,
  output logic                           s_axi_ctrl_bvalid,
  input  logic                           s_axi_ctrl_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_ctrl_araddr,
  input  logic                           s_axi_ctrl_arvalid,
  output logic                           s_axi_ctrl_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_ctrl_rdata,
  output logic [1:0]                     s_axi_ctrl_rresp,
  output logic                           s_axi_ctrl_rvalid,
  input  logic                           s_axi_ctrl_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  wr_state_e             wr_state, wr_next;
  rd_state_e             rd_state, rd_next;
  logic                  rst_done;
  logic                  aw_held, w_held, aw_ok_q;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic                  aw_ok, ar_ok;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [DATA_WIDTH-1:0] rd_word;

  axi4_lite_slv_addr_dec #(
    .ADDR_WIDTH(ADDR_WIDTH), .ADDR_LSB(ADDR_LSB), .NUM_REGS(NUM_REGS)
  ) u_aw_dec (
    .addr(s_axi_ctrl_awaddr), .idx(aw_idx), .in_range(aw_ok)
  );

  axi4_lite_slv_addr_dec #(
    .ADDR_WIDTH(ADDR_WIDTH), .ADDR_LSB(ADDR_LSB), .NUM_REGS(NUM_REGS)
  ) u_ar_dec (
    .addr(s_axi_ctrl_araddr), .idx(ar_idx), .in_range(ar_ok)
  );

  // rst_done keeps the readies low while in reset; they rise one cycle after release.
  assign s_axi_ctrl_awready = rst_done && !aw_held && (wr_state == WR_IDLE);
  assign s_axi_ctrl_wready  = rst_done && !w_held && (wr_state == WR_IDLE);
  assign s_axi_ctrl_arready = rst_done && (rd_state == RD_IDLE);
  assign s_axi_ctrl_bvalid  = (wr_state == WR_RESP);
  assign s_axi_ctrl_rvalid  = (rd_state == RD_DATA);

  assign aw_hs  = s_axi_ctrl_awvalid && s_axi_ctrl_awready;
  assign w_hs   = s_axi_ctrl_wvalid && s_axi_ctrl_wready;
  assign ar_hs  = s_axi_ctrl_arvalid && s_axi_ctrl_arready;
  assign commit = (wr_state == WR_COMMIT);

`ifndef AXI4L_SLV_WSTRB_EN
  assign wstrb_q = '1;
`endif

  // Counting the in-flight handshake as held gives the 2-cycle write latency.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) wr_next = WR_COMMIT;
      WR_COMMIT: wr_next = WR_RESP;
      WR_RESP:   if (s_axi_ctrl_bready) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (s_axi_ctrl_rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_idx == IDX_W'(i)) rd_word = regs[i];
  end

  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (!s_axi_ctrl_aresetn) begin
      wr_state         <= WR_IDLE;
      rd_state         <= RD_IDLE;
      rst_done         <= 1'b0;
      aw_held          <= 1'b0;
      w_held           <= 1'b0;
      aw_ok_q          <= 1'b0;
      aw_idx_q         <= '0;
      wdata_q          <= '0;
`ifdef AXI4L_SLV_WSTRB_EN
      wstrb_q          <= '0;
`endif
      s_axi_ctrl_bresp <= RESP_OKAY;
      s_axi_ctrl_rdata <= '0;
      s_axi_ctrl_rresp <= RESP_OKAY;
      reg_wr_pulse     <= '0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      rst_done <= 1'b1;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= aw_idx;
        aw_ok_q  <= aw_ok;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_ctrl_wdata;
`ifdef AXI4L_SLV_WSTRB_EN
        wstrb_q <= s_axi_ctrl_wstrb;
`endif
      end
      if (wr_state == WR_RESP && s_axi_ctrl_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      reg_wr_pulse <= '0;
      if (commit) begin
        s_axi_ctrl_bresp <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++)
          if (aw_ok_q && aw_idx_q == IDX_W'(i)) reg_wr_pulse[i] <= 1'b1;
      end
      // rdata only loads in RD_IDLE, so it stays stable while rvalid waits.
      // Sampling regs here returns the pre-write value during a same-cycle commit.
      if (ar_hs) begin
        s_axi_ctrl_rdata <= ar_ok ? rd_word : '0;
        s_axi_ctrl_rresp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (!s_axi_ctrl_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (commit && aw_ok_q) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (aw_idx_q == IDX_W'(i))
          for (int b = 0; b < STRB_W; b++)
            if (wstrb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regbank.sv
`timescale 1ns/1ps
module tb_axi4_lite_slave_regbank;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic [7:0]   awaddr = '0, araddr = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic         arvalid = 1'b0, rready = 1'b0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = 4'hF;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [511:0] reg_q;
  logic [15:0]  reg_wr_pulse;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] model [16];

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;
  vec_t vecs [0:10];

  always #5 clk = ~clk;

  axi4_lite_slave_regbank dut (
    .s_axi_ctrl_aclk(clk),
    .s_axi_ctrl_aresetn(aresetn),
    .s_axi_ctrl_awaddr(awaddr),
    .s_axi_ctrl_awvalid(awvalid),
    .s_axi_ctrl_awready(awready),
    .s_axi_ctrl_wdata(wdata),
`ifdef AXI4L_SLV_WSTRB_EN
    .s_axi_ctrl_wstrb(wstrb),
`endif
    .s_axi_ctrl_wvalid(wvalid),
    .s_axi_ctrl_wready(wready),
    .s_axi_ctrl_bresp(bresp),
    .s_axi_ctrl_bvalid(bvalid),
    .s_axi_ctrl_bready(bready),
    .s_axi_ctrl_araddr(araddr),
    .s_axi_ctrl_arvalid(arvalid),
    .s_axi_ctrl_arready(arready),
    .s_axi_ctrl_rdata(rdata),
    .s_axi_ctrl_rresp(rresp),
    .s_axi_ctrl_rvalid(rvalid),
    .s_axi_ctrl_rready(rready),
    .reg_q(reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = model[i];
    return r;
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    logic aw_done, w_done;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      tick; n++;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) check("wr_aw_w_timeout", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bvalid && n < 20) begin tick; n++; end
    if (!bvalid) check("wr_b_timeout", bvalid, 1);
    resp = bresp;
    bready = 1'b1; tick; bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    logic done;
    int n;
    araddr = a; arvalid = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 20) begin
      if (arready) done = 1'b1;
      tick; n++;
    end
    arvalid = 1'b0;
    if (!done) check("rd_ar_timeout", arready, 1);
    lat = 1;
    while (!rvalid && lat < 20) begin tick; lat++; end
    if (!rvalid) check("rd_r_timeout", rvalid, 1);
    d = rdata; resp = rresp;
    rready = 1'b1; tick; rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    int          lat;
    logic        stable;

    //          wr    addr   data          resp
    vecs[0]  = {1'b1, 8'h00, 32'h01234567, 2'b00};
    vecs[1]  = {1'b1, 8'h3C, 32'hCAFEF00D, 2'b00};
    vecs[2]  = {1'b1, 8'h05, 32'h11223344, 2'b00};
    vecs[3]  = {1'b1, 8'h40, 32'h99999999, 2'b10};
    vecs[4]  = {1'b1, 8'hFC, 32'h77777777, 2'b10};
    vecs[5]  = {1'b0, 8'h00, 32'h01234567, 2'b00};
    vecs[6]  = {1'b0, 8'h3C, 32'hCAFEF00D, 2'b00};
    vecs[7]  = {1'b0, 8'h07, 32'h11223344, 2'b00};
    vecs[8]  = {1'b0, 8'h40, 32'h00000000, 2'b10};
    vecs[9]  = {1'b0, 8'hFF, 32'h00000000, 2'b10};
    vecs[10] = {1'b0, 8'h08, 32'h00000000, 2'b00};
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state
    aresetn = 1'b0;
    repeat (3) tick;
    check("rst_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_wr_pulse}, '0);
    check("rst_reg_q", reg_q, model_flat());
    aresetn = 1'b1;
    check("ready_low_at_release", {awready, wready, arready}, 3'b000);
    tick;
    check("ready_after_release", {awready, wready, arready}, 3'b111);

    axi_read(8'h04, d, resp, lat);
    check("rd04_data", d, 32'h0);
    check("rd04_resp", resp, 2'b00);
    check("rd04_latency", lat, 1);

    // Table-driven writes and reads
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, 4'hF, resp);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
        if (vecs[i].resp == 2'b00) model[vecs[i].addr[5:2]] = vecs[i].data;
      end else begin
        axi_read(vecs[i].addr, d, resp, lat);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].data);
      end
    end
    check("reg_q_after_table", reg_q, model_flat());

    // W three cycles ahead of AW, then bready held low
    wdata = 32'hDEADBEEF; wvalid = 1'b1;
    check("wready_idle", wready, 1);
    tick; wvalid = 1'b0;
    check("wready_after_w", wready, 0);
    repeat (2) tick;
    awaddr = 8'h08; awvalid = 1'b1;
    check("awready_idle", awready, 1);
    tick; awvalid = 1'b0;
    check("bvalid_1cyc_after_aw", bvalid, 0);
    tick;
    check("bvalid_2cyc_after_aw", bvalid, 1);
    check("bresp_w_first", bresp, 2'b00);
    check("reg2_deadbeef", reg_q[64 +: 32], 32'hDEADBEEF);
    check("pulse_reg2", reg_wr_pulse, 16'h0004);
    model[2] = 32'hDEADBEEF;
    stable = 1'b1;
    tick;
    check("pulse_one_cycle", reg_wr_pulse, 16'h0000);
    if (!(bvalid && bresp == 2'b00 && !awready && !wready)) stable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (!(bvalid && bresp == 2'b00 && !awready && !wready)) stable = 1'b0;
    end
    check("b_hold_stable", stable, 1);
    bready = 1'b1; tick; bready = 1'b0;
    check("bvalid_after_hs", bvalid, 0);
    check("readies_after_hs", {awready, wready}, 2'b11);

    // AR handshake in the same cycle as the commit to that register
    awaddr = 8'h0C; wdata = 32'h55AA55AA; awvalid = 1'b1; wvalid = 1'b1;
    tick; awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h0C; arvalid = 1'b1;
    check("arready_in_commit", arready, 1);
    tick; arvalid = 1'b0;
    check("rvalid_collide", rvalid, 1);
    check("rdata_pre_write", rdata, 32'h0);
    check("bvalid_collide", bvalid, 1);
    model[3] = 32'h55AA55AA;
    bready = 1'b1; rready = 1'b1; tick; bready = 1'b0; rready = 1'b0;
    check("b_r_after_hs", {bvalid, rvalid}, 2'b00);
    axi_read(8'h0C, d, resp, lat);
    check("rd0c_post_write", d, 32'h55AA55AA);

    // Byte strobes
`ifdef AXI4L_SLV_WSTRB_EN
    axi_write(8'h04, 32'hAABBCCDD, 4'b0101, resp);
    check("strb_resp", resp, 2'b00);
    check("strb_reg1", reg_q[32 +: 32], 32'h11BB33DD);
    model[1] = 32'h11BB33DD;
    axi_write(8'h04, 32'hFFFFFFFF, 4'b0000, resp);
    check("strb0_resp", resp, 2'b00);
    check("strb0_reg1", reg_q[32 +: 32], 32'h11BB33DD);
`else
    axi_write(8'h04, 32'hAABBCCDD, 4'b0101, resp);
    check("fullword_resp", resp, 2'b00);
    check("fullword_reg1", reg_q[32 +: 32], 32'hAABBCCDD);
    model[1] = 32'hAABBCCDD;
`endif
    check("reg_q_final", reg_q, model_flat());

    // Reset with bvalid and rvalid both outstanding
    awaddr = 8'h14; wdata = 32'h12345678; araddr = 8'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick;
    check("b_r_pending", {bvalid, rvalid}, 2'b11);
    check("reg5_written", reg_q[160 +: 32], 32'h12345678);
    aresetn = 1'b0;
    tick;
    check("b_r_cleared_by_rst", {bvalid, rvalid}, 2'b00);
    check("reg_q_rst", reg_q, 512'h0);
    check("readies_in_rst", {awready, wready, arready}, 3'b000);
    aresetn = 1'b1;
    tick;
    check("readies_after_rst", {awready, wready, arready}, 3'b111);
    axi_read(8'h14, d, resp, lat);
    check("rd14_after_rst", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
